// File: rtl/audio_controller.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// audio_controller: WM8731-class serial audio master; define AUDIO_LOOPBACK_EN to feed DACDAT into the ADC path
// Revision 1.0
// ------------------------------------------------------------------------------------------
module audio_controller #(
  parameter int XCK_DIV   = 4,
  parameter int BCLK_HALF = 8,
  parameter int SAMPLE_W  = 32
) (
  input  logic                CLOCK_50,
  input  logic                RESETN,
  input  logic [SAMPLE_W-1:0] left_channel_audio_out,
  input  logic [SAMPLE_W-1:0] right_channel_audio_out,
  input  logic                write_audio_out,
  input  logic                read_audio_in,
  input  logic                AUD_ADCDAT,
  inout  wire                 AUD_BCLK,
  inout  wire                 AUD_ADCLRCK,
  inout  wire                 AUD_DACLRCK,
  output logic                audio_in_available,
  output logic [SAMPLE_W-1:0] left_channel_audio_in,
  output logic [SAMPLE_W-1:0] right_channel_audio_in,
  output logic                audio_out_allowed,
  output logic                AUD_XCK,
  output logic                AUD_DACDAT
);

  localparam int XCK_HALF = XCK_DIV / 2;
  localparam int XW       = (XCK_HALF > 1) ? $clog2(XCK_HALF) : 1;
  localparam int CW       = $clog2(BCLK_HALF);
  localparam int FRAME    = 2 * SAMPLE_W;
  localparam int BW       = $clog2(FRAME);

  localparam logic [XW-1:0] c_xck_tc   = XW'(XCK_HALF - 1);
  localparam logic [CW-1:0] c_bclk_tc  = CW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] c_bit_last = BW'(FRAME - 1);
  localparam logic [BW-1:0] c_bit_slot = BW'(SAMPLE_W);

  logic [XW-1:0]       xck_cnt_q, xck_cnt_d;
  logic                xck_q, xck_d;
  logic [CW-1:0]       bclk_cnt_q, bclk_cnt_d;
  logic                bclk_q, bclk_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                lrck_q, lrck_d;
  logic [FRAME-1:0]    dac_sr_q, dac_sr_d;
  logic [FRAME-1:0]    hold_q, hold_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
  logic                done_q, done_d;
  logic [SAMPLE_W-1:0] in_l_q, in_l_d, in_r_q, in_r_d;
  logic                avail_q, avail_d;

  logic w_bclk_tc, w_rise, w_fall, w_frame_start, w_write, w_sdin;

  assign w_bclk_tc     = (bclk_cnt_q == c_bclk_tc);
  assign w_rise        = w_bclk_tc & ~bclk_q;
  assign w_fall        = w_bclk_tc & bclk_q;
  assign w_frame_start = w_fall & (bit_q == c_bit_last);
  assign w_write       = write_audio_out & ~full_q;

`ifdef AUDIO_LOOPBACK_EN
  assign w_sdin = dac_sr_q[FRAME-1];
`else
  assign w_sdin = AUD_ADCDAT;
`endif

  always_comb begin
    xck_cnt_d  = xck_cnt_q;
    xck_d      = xck_q;
    bclk_cnt_d = bclk_cnt_q;
    bclk_d     = bclk_q;
    bit_d      = bit_q;
    lrck_d     = lrck_q;
    dac_sr_d   = dac_sr_q;
    hold_d     = hold_q;
    full_d     = full_q;
    adc_l_d    = adc_l_q;
    adc_r_d    = adc_r_q;
    done_d     = w_rise & (bit_q == c_bit_last);
    in_l_d     = in_l_q;
    in_r_d     = in_r_q;
    avail_d    = avail_q;

    if (xck_cnt_q == c_xck_tc) begin
      xck_cnt_d = '0;
      xck_d     = ~xck_q;
    end else begin
      xck_cnt_d = xck_cnt_q + XW'(1);
    end

    if (w_bclk_tc) begin
      bclk_cnt_d = '0;
      bclk_d     = ~bclk_q;
    end else begin
      bclk_cnt_d = bclk_cnt_q + CW'(1);
    end

    if (w_fall) begin
      bit_d  = (bit_q == c_bit_last) ? '0 : bit_q + BW'(1);
      lrck_d = (bit_d < c_bit_slot);
    end

    // The frame load sees the pre-write holding state, so a same-cycle write lands for the next frame.
    if (w_frame_start) begin
      dac_sr_d = full_q ? hold_q : '0;
      full_d   = 1'b0;
    end else if (w_fall) begin
      dac_sr_d = {dac_sr_q[FRAME-2:0], 1'b0};
    end

    if (w_write) begin
      hold_d = {left_channel_audio_out, right_channel_audio_out};
      full_d = 1'b1;
    end

    if (w_rise) begin
      if (lrck_q) adc_l_d = {adc_l_q[SAMPLE_W-2:0], w_sdin};
      else        adc_r_d = {adc_r_q[SAMPLE_W-2:0], w_sdin};
    end

    if (done_q) begin
      in_l_d  = adc_l_q;
      in_r_d  = adc_r_q;
      avail_d = 1'b1;
    end else if (read_audio_in && avail_q) begin
      avail_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      xck_cnt_q  <= '0;
      xck_q      <= 1'b0;
      bclk_cnt_q <= '0;
      bclk_q     <= 1'b0;
      bit_q      <= '0;
      lrck_q     <= 1'b1;
      dac_sr_q   <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      adc_l_q    <= '0;
      adc_r_q    <= '0;
      done_q     <= 1'b0;
      in_l_q     <= '0;
      in_r_q     <= '0;
      avail_q    <= 1'b0;
    end else begin
      xck_cnt_q  <= xck_cnt_d;
      xck_q      <= xck_d;
      bclk_cnt_q <= bclk_cnt_d;
      bclk_q     <= bclk_d;
      bit_q      <= bit_d;
      lrck_q     <= lrck_d;
      dac_sr_q   <= dac_sr_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      adc_l_q    <= adc_l_d;
      adc_r_q    <= adc_r_d;
      done_q     <= done_d;
      in_l_q     <= in_l_d;
      in_r_q     <= in_r_d;
      avail_q    <= avail_d;
    end
  end

  assign AUD_XCK                = xck_q;
  assign AUD_BCLK               = bclk_q;
  assign AUD_ADCLRCK            = lrck_q;
  assign AUD_DACLRCK            = lrck_q;
  assign AUD_DACDAT             = dac_sr_q[FRAME-1];
  assign audio_out_allowed      = ~full_q;
  assign audio_in_available     = avail_q;
  assign left_channel_audio_in  = in_l_q;
  assign right_channel_audio_in = in_r_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_controller.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// tb_audio_controller: directed bench for audio_controller (honours AUDIO_LOOPBACK_EN)
// Revision 1.0
// ------------------------------------------------------------------------------------------
module tb_audio_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lo, ro;
  logic        wr, rd, adcdat;
  wire         bclk, adclrck, daclrck;
  logic        avail, allowed, xck, dacdat;
  logic [31:0] lin, rin;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;
  logic [63:0] dac;

  localparam logic [63:0] ADC1 = 64'h12345678_9ABCDEF0;
  localparam logic [63:0] ADC2 = 64'h11111111_22222222;
  localparam logic [63:0] ADC3 = 64'h33333333_44444444;
  localparam logic [63:0] ADC4 = 64'hCAFEF00D_01234567;
`ifdef AUDIO_LOOPBACK_EN
  localparam logic [63:0] IN1 = 64'hA5A50001_80000000;
  localparam logic [63:0] IN2 = 64'h0;
  localparam logic [63:0] IN3 = 64'hDEADBEEF_0BADF00D;
  localparam logic [63:0] IN4 = 64'h0;
`else
  localparam logic [63:0] IN1 = ADC1;
  localparam logic [63:0] IN2 = ADC2;
  localparam logic [63:0] IN3 = ADC3;
  localparam logic [63:0] IN4 = ADC4;
`endif

  audio_controller dut (
    .CLOCK_50               (clk),
    .RESETN                 (rst_n),
    .left_channel_audio_out (lo),
    .right_channel_audio_out(ro),
    .write_audio_out        (wr),
    .read_audio_in          (rd),
    .AUD_ADCDAT             (adcdat),
    .AUD_BCLK               (bclk),
    .AUD_ADCLRCK            (adclrck),
    .AUD_DACLRCK            (daclrck),
    .audio_in_available     (avail),
    .left_channel_audio_in  (lin),
    .right_channel_audio_in (rin),
    .audio_out_allowed      (allowed),
    .AUD_XCK                (xck),
    .AUD_DACDAT             (dacdat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns just after (#1) the k-th rising clock edge since the last reset release.
  task automatic wait_edge(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_io(input int f, input logic [63:0] adc, output logic [63:0] d);
    for (int b = 0; b < 64; b++) begin
      wait_edge(1024 * f + 16 * b);
      adcdat = adc[63-b];
      wait_edge(1024 * f + 16 * b + 8);
      d[63-b] = dacdat;
    end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; adcdat = 1'b0; lo = '0; ro = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_xck", {63'b0, xck}, 64'd0);
    chk("rst_bclk", {63'b0, bclk}, 64'd0);
    chk("rst_adclrck", {63'b0, adclrck}, 64'd1);
    chk("rst_daclrck", {63'b0, daclrck}, 64'd1);
    chk("rst_dacdat", {63'b0, dacdat}, 64'd0);
    chk("rst_avail", {63'b0, avail}, 64'd0);
    chk("rst_allowed", {63'b0, allowed}, 64'd1);
    chk("rst_in", {lin, rin}, 64'd0);

    rst_n = 1'b1; t0 = cyc;
    wait_edge(1);   chk("xck_e1", {63'b0, xck}, 64'd0);
    wait_edge(2);   chk("xck_e2", {63'b0, xck}, 64'd1);
    wait_edge(4);   chk("xck_e4", {63'b0, xck}, 64'd0);
    wait_edge(7);   chk("bclk_e7", {63'b0, bclk}, 64'd0);
    wait_edge(8);   chk("bclk_e8", {63'b0, bclk}, 64'd1);
    wait_edge(16);  chk("bclk_e16", {63'b0, bclk}, 64'd0);
    wait_edge(24);  chk("bclk_e24", {63'b0, bclk}, 64'd1);
    wait_edge(511); chk("lrck_e511", {63'b0, adclrck}, 64'd1);
    wait_edge(512); chk("lrck_e512", {62'b0, adclrck, daclrck}, 64'd0);

    wait_edge(600); chk("allowed_pre_wr", {63'b0, allowed}, 64'd1);
    lo = 32'hA5A50001; ro = 32'h80000000; wr = 1'b1;
    wait_edge(601); wr = 1'b0; chk("allowed_after_wr", {63'b0, allowed}, 64'd0);
    wait_edge(700); lo = 32'hFFFFFFFF; ro = 32'hFFFFFFFF; wr = 1'b1;
    wait_edge(701); wr = 1'b0; chk("allowed_ignored_wr", {63'b0, allowed}, 64'd0);

    wait_edge(1016); chk("avail_f0_pre", {63'b0, avail}, 64'd0);
    wait_edge(1017); chk("avail_f0", {63'b0, avail}, 64'd1);
    rd = 1'b1;
    wait_edge(1018); rd = 1'b0; chk("avail_f0_read", {63'b0, avail}, 64'd0);
    wait_edge(1023); chk("allowed_e1023", {63'b0, allowed}, 64'd0);
    chk("lrck_e1023", {63'b0, adclrck}, 64'd0);
    wait_edge(1024); chk("allowed_load", {63'b0, allowed}, 64'd1);
    chk("lrck_e1024", {63'b0, adclrck}, 64'd1);

    frame_io(1, ADC1, dac);
    chk("dac_frame1", dac, 64'hA5A50001_80000000);
    chk("avail_e2040", {63'b0, avail}, 64'd0);
    wait_edge(2041);
    chk("avail_f1", {63'b0, avail}, 64'd1);
    chk("in_f1", {lin, rin}, IN1);
    rd = 1'b1;
    wait_edge(2042); rd = 1'b0;
    chk("avail_f1_read", {63'b0, avail}, 64'd0);
    chk("in_f1_held", {lin, rin}, IN1);

    frame_io(2, ADC2, dac);
    chk("dac_underrun", dac, 64'd0);
    wait_edge(3065);
    chk("avail_f2", {63'b0, avail}, 64'd1);
    chk("in_f2", {lin, rin}, IN2);
    lo = 32'hDEADBEEF; ro = 32'h0BADF00D; wr = 1'b1;
    wait_edge(3066); wr = 1'b0; chk("allowed_f2_wr", {63'b0, allowed}, 64'd0);
    wait_edge(3071); chk("allowed_e3071", {63'b0, allowed}, 64'd0);
    wait_edge(3072); chk("allowed_e3072", {63'b0, allowed}, 64'd1);

    frame_io(3, ADC3, dac);
    chk("dac_frame3", dac, 64'hDEADBEEF_0BADF00D);
    wait_edge(4088);
    chk("avail_overrun_hold", {63'b0, avail}, 64'd1);
    chk("in_f2_unread", {lin, rin}, IN2);
    wait_edge(4089);
    chk("avail_overrun", {63'b0, avail}, 64'd1);
    chk("in_f3", {lin, rin}, IN3);

    wait_edge(4095); lo = 32'hC0000000; ro = 32'h00000001; wr = 1'b1;
    wait_edge(4096); wr = 1'b0; chk("allowed_wr_at_load", {63'b0, allowed}, 64'd0);
    frame_io(4, ADC4, dac);
    chk("dac_frame4_empty_load", dac, 64'd0);
    rd = 1'b1;
    wait_edge(5113); rd = 1'b0;
    chk("avail_read_and_done", {63'b0, avail}, 64'd1);
    chk("in_f4", {lin, rin}, IN4);
    wait_edge(5119); chk("allowed_e5119", {63'b0, allowed}, 64'd0);
    wait_edge(5120); chk("allowed_e5120", {63'b0, allowed}, 64'd1);
    wait_edge(5128); chk("dac_f5_b0", {63'b0, dacdat}, 64'd1);
    wait_edge(5144); chk("dac_f5_b1", {63'b0, dacdat}, 64'd1);
    wait_edge(5160); chk("dac_f5_b2", {63'b0, dacdat}, 64'd0);

    wait_edge(5200); lo = 32'hFFFFFFFF; ro = 32'hFFFFFFFF; wr = 1'b1;
    wait_edge(5201); wr = 1'b0; chk("allowed_pending", {63'b0, allowed}, 64'd0);
    wait_edge(5310);
    chk("pre_rst_clocks", {62'b0, bclk, xck}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_xck", {63'b0, xck}, 64'd0);
    chk("mid_rst_bclk", {63'b0, bclk}, 64'd0);
    chk("mid_rst_lrck", {62'b0, adclrck, daclrck}, 64'd3);
    chk("mid_rst_dacdat", {63'b0, dacdat}, 64'd0);
    chk("mid_rst_avail", {63'b0, avail}, 64'd0);
    chk("mid_rst_allowed", {63'b0, allowed}, 64'd1);
    chk("mid_rst_in", {lin, rin}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; t0 = cyc;
    wait_edge(1023); chk("allowed_after_rst", {63'b0, allowed}, 64'd1);
    frame_io(1, ADC1, dac);
    chk("dac_pending_discarded", dac, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
